alu_pipe: RTL and testbench

Parametrised, pipelined successor to the 8-bit combinational ALU. Accepts one operation per cycle through a valid/ready handshake, executes it over a two-stage registered pipeline, and returns the result with carry, zero, negative and overflow flags. An internal accumulator can supply operand A and capture results, so dependent operations chain back-to-back without external feedback. It sits between the instruction sequencer and the register-file writeback path.

---
 rtl/alu_pipe.sv | 173 +++++++++++++++++
 tb/tb_alu_pipe.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with a valid/ready handshake on both sides.
// S1 captures the request. The S1->S2 transfer computes the result and flags
// and can optionally write the internal accumulator. S2 is the output register.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_Sel,
    input  logic             use_acc,
    input  logic             acc_wr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_Out,
    output logic             CarryOut,
    output logic             Zero,
    output logic             Negative,
    output logic             Overflow,
    output logic [WIDTH-1:0] acc
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_PASS = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_NOT  = 4'd11;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [3:0]       s1_sel;
    logic             s1_use_acc;
    logic             s1_acc_wr;
    logic             s2_valid;

    logic             s2_load;
    logic             s1_load;
    logic             in_fire;

    logic [WIDTH-1:0] op_a;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_v;
    logic             res_z;
    logic             res_n;
    logic             op_defined;
    logic [WIDTH:0]   ext;
    logic signed [WIDTH:0] sext;

    // S2 can take a new op when empty or being consumed; S1 frees up when
    // empty or when its op moves into S2 this cycle.
    assign s2_load   = !s2_valid || out_ready;
    assign s1_load   = !s1_valid || s2_load;
    assign in_ready  = !rst && (!s1_valid || !s2_valid || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_valid = s2_valid;

    // The accumulator is read here, not in S1, so in-order execution alone
    // guarantees a use_acc op sees every earlier acc write.
    assign op_a = s1_use_acc ? acc : s1_a;
    assign sh   = s1_b[SHW-1:0];

    // Result and flag computation for the op sitting in S1.
    always_comb begin
        res        = '0;
        res_c      = 1'b0;
        res_v      = 1'b0;
        op_defined = 1'b1;
        ext        = '0;
        sext       = '0;
        case (s1_sel)
            OP_ADD: begin
                ext   = {1'b0, op_a} + {1'b0, s1_b};
                res   = ext[WIDTH-1:0];
                res_c = ext[WIDTH];
                res_v = (op_a[WIDTH-1] == s1_b[WIDTH-1]) && (res[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUB: begin
                ext   = {1'b0, op_a} - {1'b0, s1_b};
                res   = ext[WIDTH-1:0];
                res_c = ext[WIDTH];
                res_v = (op_a[WIDTH-1] != s1_b[WIDTH-1]) && (res[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_AND:  res = op_a & s1_b;
            OP_OR:   res = op_a | s1_b;
            OP_XOR:  res = op_a ^ s1_b;
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(s1_b))};
            OP_PASS: res = op_a;
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, (op_a < s1_b)};
            OP_SHL: begin
                // Extra MSB catches the last bit shifted out; zero for sh==0.
                ext   = {1'b0, op_a} << sh;
                res   = ext[WIDTH-1:0];
                res_c = ext[WIDTH];
            end
            OP_SHR: begin
                ext   = {op_a, 1'b0} >> sh;
                res   = ext[WIDTH:1];
                res_c = ext[0];
            end
            OP_SRA: begin
                sext  = $signed({op_a, 1'b0}) >>> sh;
                res   = sext[WIDTH:1];
                res_c = sext[0];
            end
            OP_NOT:  res = ~op_a;
            default: op_defined = 1'b0;
        endcase
        res_z = (res == '0);
        res_n = res[WIDTH-1];
    end

    // Stage 1: capture the accepted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_sel     <= '0;
            s1_use_acc <= 1'b0;
            s1_acc_wr  <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= in_fire;
            if (in_fire) begin
                s1_a       <= A;
                s1_b       <= B;
                s1_sel     <= ALU_Sel;
                s1_use_acc <= use_acc;
                s1_acc_wr  <= acc_wr;
            end
        end
    end

    // Stage 2: output register and accumulator write, both on the S1->S2 transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            ALU_Out  <= '0;
            CarryOut <= 1'b0;
            Zero     <= 1'b0;
            Negative <= 1'b0;
            Overflow <= 1'b0;
            acc      <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                ALU_Out  <= res;
                CarryOut <= res_c;
                Zero     <= res_z;
                Negative <= res_n;
                Overflow <= res_v;
                if (s1_acc_wr && op_defined) begin
                    acc <= res;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=8): issued ops push expected results,
// a negedge monitor pops and compares every consumed output.
module tb_alu_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] ALU_Sel;
    logic       use_acc;
    logic       acc_wr;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] ALU_Out;
    logic       CarryOut;
    logic       Zero;
    logic       Negative;
    logic       Overflow;
    logic [7:0] acc;

    typedef struct {
        logic [7:0] r;
        logic [3:0] f;   // {C, Z, N, V}
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   n_acc  = 0;

    alu_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ALU_Sel(ALU_Sel), .use_acc(use_acc), .acc_wr(acc_wr),
        .out_valid(out_valid), .out_ready(out_ready), .ALU_Out(ALU_Out),
        .CarryOut(CarryOut), .Zero(Zero), .Negative(Negative), .Overflow(Overflow),
        .acc(acc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Present one request and hold it until accepted; the expectation is
    // queued in the cycle the handshake completes.
    task automatic issue(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b,
                         input logic ua, input logic aw, input logic [7:0] r, input logic [3:0] f);
        exp_t e;
        bit   done = 0;
        e.r = r;
        e.f = f;
        in_valid = 1'b1; ALU_Sel = sel; A = a; B = b; use_acc = ua; acc_wr = aw;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                n_acc++;
                done = 1;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: op %0d never accepted", sel);
        end
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        chk(nm, sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every consumed result with the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %0h with no op outstanding", ALU_Out);
            end else begin
                mon_e = sb.pop_front();
                if ({ALU_Out, CarryOut, Zero, Negative, Overflow} !== {mon_e.r, mon_e.f}) begin
                    errors++;
                    $display("FAIL result: got %0h CZNV=%b expected %0h CZNV=%b",
                             ALU_Out, {CarryOut, Zero, Negative, Overflow}, mon_e.r, mon_e.f);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; ALU_Sel = '0; use_acc = 1'b0; acc_wr = 1'b0;
        #12;
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_acc", acc, 0);
        chk("reset_flags", {ALU_Out, CarryOut, Zero, Negative, Overflow}, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Basic ops, back-to-back, A=10 B=5
        issue(4'd0, 8'd10, 8'd5, 0, 0, 8'd15, 4'b0000);
        issue(4'd1, 8'd10, 8'd5, 0, 0, 8'd5,  4'b0000);
        issue(4'd2, 8'd10, 8'd5, 0, 0, 8'd0,  4'b0100);
        issue(4'd3, 8'd10, 8'd5, 0, 0, 8'd15, 4'b0000);
        issue(4'd4, 8'd10, 8'd5, 0, 0, 8'd15, 4'b0000);
        issue(4'd5, 8'd10, 8'd5, 0, 0, 8'd0,  4'b0100);
        issue(4'd6, 8'd10, 8'd5, 0, 0, 8'd10, 4'b0000);
        drain("basic_drain");

        // Arithmetic flags
        issue(4'd0, 8'hFF, 8'h01, 0, 0, 8'h00, 4'b1100);
        issue(4'd0, 8'h7F, 8'h01, 0, 0, 8'h80, 4'b0011);
        issue(4'd1, 8'd5,  8'd10, 0, 0, 8'hFB, 4'b1010);
        issue(4'd1, 8'h80, 8'h01, 0, 0, 8'h7F, 4'b0001);
        issue(4'd5, 8'h80, 8'h01, 0, 0, 8'h01, 4'b0000);
        issue(4'd7, 8'h80, 8'h01, 0, 0, 8'h00, 4'b0100);
        issue(4'd11, 8'h0F, 8'h00, 0, 0, 8'hF0, 4'b0010);
        drain("arith_drain");

        // Shifts
        issue(4'd8,  8'h81, 8'd1, 0, 0, 8'h02, 4'b1000);
        issue(4'd10, 8'h90, 8'd2, 0, 0, 8'hE4, 4'b0010);
        issue(4'd9,  8'h03, 8'd1, 0, 0, 8'h01, 4'b1000);
        issue(4'd8,  8'h81, 8'd0, 0, 0, 8'h81, 4'b0010);
        issue(4'd9,  8'h80, 8'd7, 0, 0, 8'h01, 4'b0000);
        drain("shift_drain");

        // Accumulator chain (A ignored on use_acc ops)
        issue(4'd6, 8'd3,  8'd0, 0, 1, 8'd3,  4'b0000);
        issue(4'd0, 8'h99, 8'd4, 1, 1, 8'd7,  4'b0000);
        issue(4'd0, 8'h99, 8'd4, 1, 1, 8'd11, 4'b0000);
        drain("chain_drain");
        chk("chain_acc", acc, 8'd11);

        // Undefined opcode must not touch acc
        issue(4'd15, 8'h22, 8'h33, 0, 1, 8'h00, 4'b0100);
        drain("undef_drain");
        chk("undef_acc", acc, 8'd11);

        // Backpressure: third request held until out_ready returns
        out_ready = 1'b0;
        n_acc = 0;
        fork
            begin
                issue(4'd0, 8'd1,  8'd2,  0, 0, 8'd3,  4'b0000);
                issue(4'd1, 8'd9,  8'd4,  0, 0, 8'd5,  4'b0000);
                issue(4'd4, 8'hF0, 8'h0F, 0, 0, 8'hFF, 4'b0010);
            end
            begin
                repeat (4) @(posedge clk);
                #2;
                chk("bp_accepted", n_acc, 2);
                chk("bp_in_ready", in_ready, 0);
                chk("bp_out_valid", out_valid, 1);
                chk("bp_hold_out", ALU_Out, 8'd3);
                out_ready = 1'b1;
            end
        join
        drain("bp_drain");
        chk("bp_total", n_acc, 3);

        // Reset with both stages full
        out_ready = 1'b0;
        issue(4'd6, 8'h55, 8'h00, 0, 1, 8'h55, 4'b0000);
        issue(4'd0, 8'd3,  8'd3,  0, 0, 8'd6,  4'b0000);
        chk("pre_rst_acc", acc, 8'h55);
        chk("pre_rst_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_acc", acc, 0);
        chk("rst_flags", {ALU_Out, CarryOut, Zero, Negative, Overflow}, 0);
        chk("rst_in_ready", in_ready, 0);
        sb.delete();
        @(negedge clk); rst = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        issue(4'd0, 8'd1, 8'd1, 0, 0, 8'd2, 4'b0000);
        @(negedge clk);
        chk("post_rst_lat1", out_valid, 0);
        @(negedge clk);
        chk("post_rst_lat2", out_valid, 1);
        chk("post_rst_out", ALU_Out, 8'd2);
        drain("post_rst_drain");
        chk("post_rst_acc", acc, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
